// File: rtl/psum_drain.sv
// psum_drain: column-bottom partial-sum consumer.
// Extends each column psum, accumulates num_pass beats into one result, and
// queues finished results in a small FIFO drained over valid/ready.
// Optional saturation is enabled by defining PSUM_DRAIN_SAT_EN; otherwise adds
// wrap and out_sat is tied low.
module psum_drain #(
  parameter int COL_WIDTH = 11,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [2*COL_WIDTH-1:0] psum_in,
  input  logic                   s_psum,
  input  logic [3:0]             num_pass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  output logic                   busy
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [3:0]           cnt;
  logic [3:0]           np_q;
  logic                 s_psum_q;

  logic [ACC_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 s_eff;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] add_res;
  logic [ACC_WIDTH-1:0] next_acc;
  logic [3:0]           np_eff;
  logic [3:0]           next_cnt;

  assign psum_ready = (count < CW'(OUT_DEPTH));
  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];
  assign busy       = (state == ACCUM);

  // Beat handshake, extension and group-completion decode.
  // In IDLE the live s_psum/num_pass govern the first beat of a new group.
  always_comb begin
    accept   = psum_valid && psum_ready;
    pop      = out_valid && out_ready;
    s_eff    = (state == IDLE) ? s_psum : s_psum_q;
    ext      = s_eff ? ACC_WIDTH'($signed(psum_in)) : ACC_WIDTH'(psum_in);
    np_eff   = (state == IDLE) ? ((num_pass == 4'd0) ? 4'd1 : num_pass) : np_q;
    next_cnt = (state == IDLE) ? 4'd1 : cnt + 4'd1;
    next_acc = (state == IDLE) ? ext : add_res;
    push     = accept && (next_cnt == np_eff);
  end

`ifdef PSUM_DRAIN_SAT_EN
  logic                 sat_q;
  logic                 add_ovf;
  logic                 next_sat;
  logic [ACC_WIDTH:0]   sum;
  logic                 mem_sat [OUT_DEPTH];

  assign out_sat = mem_sat[rd_ptr];

  // Widened add with overflow detection and clamp to the active signedness.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, ext};
    add_ovf = 1'b0;
    add_res = sum[ACC_WIDTH-1:0];
    if (s_psum_q)
      add_ovf = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    else
      add_ovf = sum[ACC_WIDTH];
    if (add_ovf) begin
      if (s_psum_q)
        add_res = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
        add_res = '1;
    end
    next_sat = (state == IDLE) ? 1'b0 : (sat_q | add_ovf);
  end

  // Sticky group saturation flag and its FIFO side-storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem_sat[i] <= 1'b0;
    end else if (clr) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= next_sat;
      if (push) mem_sat[wr_ptr] <= next_sat;
    end
  end
`else
  assign out_sat = 1'b0;

  // Plain wrapping add.
  always_comb begin
    add_res = acc + ext;
  end
`endif

  // Group FSM: IDLE starts a group, ACCUM adds beats until np_q reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      np_q     <= 4'd1;
      s_psum_q <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      acc <= next_acc;
      cnt <= next_cnt;
      if (state == IDLE) begin
        s_psum_q <= s_psum;
        np_q     <= np_eff;
      end
      state <= push ? IDLE : ACCUM;
    end
  end

  // Result FIFO: push on group completion, pop on out handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= next_acc;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
